// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM with optional parity,
// and a valid/ready output register with frame/parity error pulses and sticky overrun.
module uart_rx #(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT     = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic             r_par_bad;
  logic             r_sync1;
  logic             r_rxs;
  logic             r_rxs_d;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_parity_err;
  logic             r_overrun;

  logic w_fall;
  logic w_bit_end;
  logic w_par_xor;
  logic w_load_ok;

  assign w_fall    = r_rxs_d & ~r_rxs;
  assign w_bit_end = (r_cnt == CNT_BIT_END);
  // Unused upper shift-register bits stay 0, so the full reduction covers only data bits.
  assign w_par_xor = (^r_shreg) ^ r_rxs;
  assign w_load_ok = ~r_rx_valid | rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shreg      <= '0;
      r_par_bad    <= 1'b0;
      r_sync1      <= 1'b1;
      r_rxs        <= 1'b1;
      r_rxs_d      <= 1'b1;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_rxs        <= r_sync1;
      r_rxs_d      <= r_rxs;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;

      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (clr_err) r_overrun <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == CNT_HALF_END) begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_state <= StIdle;
            end else begin
              r_state   <= StData;
              r_bit_idx <= '0;
              r_shreg   <= '0;
              r_par_bad <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt              <= '0;
            r_shreg[r_bit_idx] <= r_rxs;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= (PARITY_MODE != 0) ? StParity : StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bad <= (PARITY_MODE == 1) ? ~w_par_xor : w_par_xor;
            r_state   <= StStop;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= StIdle;
            if (!r_rxs) begin
              r_frame_err <= 1'b1;
            end else if (r_par_bad) begin
              r_parity_err <= 1'b1;
            end else if (w_load_ok) begin
              r_rx_data  <= r_shreg;
              r_rx_valid <= 1'b1;
            end else begin
              // Placed after the clr_err clear so a same-cycle overrun wins.
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
